// File: rtl/draw_cmd_arbiter.sv
// Two-requester arbiter for the command-processor byte bus: accepts one draw
// command per handshake, emits its bytes back to back, then idles a gap.

module draw_cmd_req_fmt (
  input  logic [1:0] i_op,
  input  logic       i_clr,
  input  logic [2:0] i_p0,
  output logic [7:0] o_byte0,
  output logic [1:0] o_last,
  output logic       o_noop
);
  always_comb begin
    o_noop  = (i_op == 2'b00);
    o_byte0 = {1'b1, i_op, 2'b00, i_p0};
    o_last  = 2'd3;
    if (i_op == 2'b01) begin
      if (i_clr) begin
        o_byte0 = 8'hBF;
        o_last  = 2'd0;
      end else begin
        o_last  = 2'd1;
      end
    end
  end
endmodule

module draw_cmd_arbiter #(
  parameter int GAP_CYCLES = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [1:0]  req_clr,
  input  logic [23:0] req_par,
  output logic [7:0]  out_byte,
  output logic        busy,
  output logic        grant_id,
  output logic        cmd_done
);
  localparam int         GAP      = (GAP_CYCLES < 1) ? 1 : ((GAP_CYCLES > 7) ? 7 : GAP_CYCLES);
  localparam logic [2:0] GAP_LOAD = 3'(GAP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]      r_state;
  logic [7:0]      r_out;
  logic [1:0]      r_cnt;
  logic [1:0]      r_last;
  logic [8:0]      r_par;   // p3..p1; p0 already went out in byte0
  logic [2:0]      r_gcnt;
  logic            r_rr;
  logic            r_grant;
  logic            r_done;

  logic [1:0][7:0] w_byte0;
  logic [1:0][1:0] w_last;
  logic [1:0]      w_noop;
  logic            w_sel;
  logic            w_xfer;
  logic [11:0]     w_par;
  logic [1:0]      w_nxt;
  logic [2:0]      w_pk;

  for (genvar g = 0; g < 2; g++) begin : g_req
    draw_cmd_req_fmt u_fmt (
      .i_op    (req_cmd[2*g +: 2]),
      .i_clr   (req_clr[g]),
      .i_p0    (req_par[12*g +: 3]),
      .o_byte0 (w_byte0[g]),
      .o_last  (w_last[g]),
      .o_noop  (w_noop[g])
    );
  end

  always_comb begin
    if (req_valid == 2'b11) w_sel = FIXED_PRIO ? 1'b0 : r_rr;
    else                    w_sel = req_valid[1];
    req_ready = 2'b00;
    if (r_state == S_IDLE && !rst && req_valid != 2'b00) req_ready[w_sel] = 1'b1;
  end

  assign w_xfer = |req_ready;
  assign w_par  = w_sel ? req_par[23:12] : req_par[11:0];
  assign w_nxt  = r_cnt + 2'd1;

  always_comb begin
    case (w_nxt)
      2'd1:    w_pk = r_par[2:0];
      2'd2:    w_pk = r_par[5:3];
      2'd3:    w_pk = r_par[8:6];
      default: w_pk = 3'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= 8'h00;
      r_cnt   <= 2'd0;
      r_last  <= 2'd0;
      r_par   <= 9'd0;
      r_gcnt  <= 3'd0;
      r_rr    <= 1'b0;
      r_grant <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (w_xfer) begin
          r_grant <= w_sel;
          r_rr    <= ~w_sel;
          // NO_OP completes the handshake but never reaches the bus
          if (!w_noop[w_sel]) begin
            r_state <= S_SEND;
            r_out   <= w_byte0[w_sel];
            r_last  <= w_last[w_sel];
            r_par   <= w_par[11:3];
            r_cnt   <= 2'd0;
          end
        end
        S_SEND: if (r_cnt == r_last) begin
          r_state <= S_GAP;
          r_out   <= 8'h00;
          r_done  <= 1'b1;
          r_gcnt  <= GAP_LOAD;
        end else begin
          r_cnt <= w_nxt;
          r_out <= {5'b10000, w_pk};
        end
        S_GAP: if (r_gcnt == 3'd0) r_state <= S_IDLE;
               else                r_gcnt  <= r_gcnt - 3'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_byte = r_out;
  assign busy     = (r_state != S_IDLE);
  assign grant_id = r_grant;
  assign cmd_done = r_done;
endmodule

// File: tb/tb_draw_cmd_arbiter.sv
// Bench for draw_cmd_arbiter: vector table of single handshakes plus
// hand sequences for throughput, mid-command reset and fixed priority.

module tb_draw_cmd_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid, req_ready, req_clr;
  logic [3:0]  req_cmd;
  logic [23:0] req_par;
  logic [7:0]  out_byte;
  logic        busy, grant_id, cmd_done;

  logic [1:0]  fp_valid, fp_ready, fp_clr;
  logic [3:0]  fp_cmd;
  logic [23:0] fp_par;
  logic [7:0]  fp_out;
  logic        fp_busy, fp_grant, fp_done;

  draw_cmd_arbiter #(.GAP_CYCLES(1), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_clr(req_clr), .req_par(req_par),
    .out_byte(out_byte), .busy(busy), .grant_id(grant_id), .cmd_done(cmd_done)
  );

  draw_cmd_arbiter #(.GAP_CYCLES(3), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .req_valid(fp_valid), .req_ready(fp_ready),
    .req_cmd(fp_cmd), .req_clr(fp_clr), .req_par(fp_par),
    .out_byte(fp_out), .busy(fp_busy), .grant_id(fp_grant), .cmd_done(fp_done)
  );

  typedef logic [7:0] b4_t [4];
  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  op0;
    logic        clr0;
    logic [11:0] par0;
    logic [1:0]  op1;
    logic        clr1;
    logic [11:0] par1;
    logic [1:0]  ready;
    logic        grant;
    int          len;
    b4_t         b;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       done;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  vec_t vt[10];
  int   last, ng, bad, nd;
  bit   got;
  b4_t  pix;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_cmd(input b4_t b, input int len, input int gap);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.b = b[i]; e.done = 1'b0; sb.push_back(e);
    end
    if (len > 0)
      for (int i = 0; i < gap; i++) begin
        e.b = 8'h00; e.done = (i == 0); sb.push_back(e);
      end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 50) begin @(negedge clk); k++; end
    if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    wait_idle();
    chk("sb_drained", sb.size(), 0);
    @(posedge clk); #1;
    req_valid = v.valid;
    req_cmd   = {v.op1, v.op0};
    req_clr   = {v.clr1, v.clr0};
    req_par   = {v.par1, v.par0};
    @(negedge clk);
    chk("req_ready", {30'd0, req_ready}, {30'd0, v.ready});
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("grant_id", {31'd0, grant_id}, {31'd0, v.grant});
    push_cmd(v.b, v.len, 1);
  endtask

  // scoreboard: every busy cycle consumes one expected bus byte
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (busy) begin
        if (sb.size() == 0) chk("extra_bus_cycle", {23'd0, busy, out_byte}, 32'd0);
        else begin
          mon_e = sb.pop_front();
          chk("out_byte", {24'd0, out_byte}, {24'd0, mon_e.b});
          chk("cmd_done", {31'd0, cmd_done}, {31'd0, mon_e.done});
        end
      end else begin
        chk("idle_out", {24'd0, out_byte}, 32'd0);
        chk("idle_done", {31'd0, cmd_done}, 32'd0);
      end
    end
  end

  initial begin
    // {valid, op0,clr0,par0, op1,clr1,par1, ready, grant, len, bytes}
    vt[0] = '{2'b01, 2'b01, 1'b0, 12'h02B, 2'b00, 1'b0, 12'h000, 2'b01, 1'b0, 2, '{8'hA3, 8'h85, 8'h00, 8'h00}};
    vt[1] = '{2'b10, 2'b00, 1'b0, 12'h000, 2'b01, 1'b1, 12'h000, 2'b10, 1'b1, 1, '{8'hBF, 8'h00, 8'h00, 8'h00}};
    vt[2] = '{2'b11, 2'b10, 1'b0, 12'hF91, 2'b11, 1'b0, 12'h8C0, 2'b01, 1'b0, 4, '{8'hC1, 8'h82, 8'h86, 8'h87}};
    vt[3] = '{2'b11, 2'b10, 1'b0, 12'hF91, 2'b11, 1'b0, 12'h8C0, 2'b10, 1'b1, 4, '{8'hE0, 8'h80, 8'h83, 8'h84}};
    vt[4] = '{2'b11, 2'b01, 1'b0, 12'h007, 2'b11, 1'b0, 12'h8C0, 2'b01, 1'b0, 2, '{8'hA7, 8'h80, 8'h00, 8'h00}};
    vt[5] = '{2'b10, 2'b00, 1'b0, 12'h000, 2'b10, 1'b1, 12'h29C, 2'b10, 1'b1, 4, '{8'hC4, 8'h83, 8'h82, 8'h81}};
    vt[6] = '{2'b01, 2'b00, 1'b0, 12'h000, 2'b00, 1'b0, 12'h000, 2'b01, 1'b0, 0, '{8'h00, 8'h00, 8'h00, 8'h00}};
    vt[7] = '{2'b11, 2'b11, 1'b0, 12'hFFF, 2'b01, 1'b0, 12'h032, 2'b10, 1'b1, 2, '{8'hA2, 8'h86, 8'h00, 8'h00}};
    vt[8] = '{2'b10, 2'b00, 1'b0, 12'h000, 2'b00, 1'b0, 12'h000, 2'b10, 1'b1, 0, '{8'h00, 8'h00, 8'h00, 8'h00}};
    vt[9] = '{2'b11, 2'b11, 1'b0, 12'hFFF, 2'b01, 1'b0, 12'h032, 2'b01, 1'b0, 4, '{8'hE7, 8'h87, 8'h87, 8'h87}};
    pix = '{8'hA3, 8'h85, 8'h00, 8'h00};

    rst = 1'b1;
    req_valid = 2'b01; req_cmd = 4'b0001; req_clr = 2'b00; req_par = 24'h0;
    fp_valid = 2'b11;  fp_cmd = 4'b0101;  fp_clr = 2'b00;  fp_par = 24'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_out", {24'd0, out_byte}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {31'd0, grant_id}, 32'd0);
    chk("rst_done", {31'd0, cmd_done}, 32'd0);
    chk("rst_fp_ready", {30'd0, fp_ready}, 32'd0);
    req_valid = 2'b00; fp_valid = 2'b00;
    #1 rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // back-to-back PIXEL from one requester: accept every 1+2+GAP cycles
    wait_idle();
    @(posedge clk); #1;
    req_valid = 2'b01; req_cmd = 4'b0001; req_clr = 2'b00; req_par = 24'h00002B;
    last = -1; ng = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        if (last >= 0) chk("pixel_interval", c - last, 4);
        last = c; ng++;
        push_cmd(pix, 2, 1);
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("pixel_grants", ng, 5);

    // reset while the third LINE byte is on the bus
    wait_idle();
    @(posedge clk); #1;
    req_valid = 2'b01; req_cmd = 4'b0010; req_par = 24'h000F91;
    @(posedge clk); #1;
    req_valid = 2'b00;
    push_cmd(vt[2].b, 4, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b0;
    chk("line_byte3", {24'd0, out_byte}, 32'h86);
    #1 rst = 1'b1;
    #1;
    chk("arst_out", {24'd0, out_byte}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    @(negedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    run_vec(vt[2]);
    run_vec(vt[3]);

    // fixed priority: req1 starves while req0 keeps asking
    @(posedge clk); #1;
    fp_valid = 2'b11; fp_cmd = 4'b0101; fp_clr = 2'b00; fp_par = {12'h02B, 12'h02B};
    last = -1; ng = 0; bad = 0; nd = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (fp_ready[1]) bad++;
      if (fp_done) nd++;
      if (fp_ready[0]) begin
        if (last >= 0) chk("fp_interval", c - last, 6);
        last = c; ng++;
      end
    end
    chk("fp_req1_starved", bad, 0);
    chk("fp_req0_grants", ng, 7);
    chk("fp_done_pulses", nd, 7);
    @(posedge clk); #1;
    fp_valid = 2'b10;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (fp_ready == 2'b10) got = 1'b1;
    end
    chk("fp_req1_after_drop", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    fp_valid = 2'b00;
    chk("fp_grant1", {31'd0, fp_grant}, 32'd1);

    wait_idle();
    chk("sb_empty", sb.size(), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
